// File: rtl/pc_ctrl.sv
// Program counter / sequencer behind the ALU: sequential, absolute and relative redirects via a writable target table.
// One-cycle redirect latency. Outputs are registered or decoded from state. No backpressure: stall holds the PC in place.
module pc_ctrl #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              halt,
  input  logic              branch_en,
  input  logic              abs_jump,
  input  logic              jump_flag,
  input  logic [LUT_AW-1:0] lut_idx,
  input  logic              lut_we,
  input  logic [LUT_AW-1:0] lut_waddr,
  input  logic [PC_W-1:0]   lut_wdata,
  output logic [PC_W-1:0]   pc,
  output logic              running,
  output logic              done,
  output logic              pc_wrap_err,
  output logic [CNT_W-1:0]  cycle_cnt
);

  localparam int LUT_N = 1 << LUT_AW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              wrap_err_q, wrap_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PC_W-1:0]   lut_q [LUT_N];
  logic [PC_W-1:0]   lut_d [LUT_N];
  logic [PC_W-1:0]   target;

  // Read sees pre-edge contents, so a same-cycle write to this index is not forwarded.
  assign target = lut_q[lut_idx];

  always_comb begin
    lut_d = lut_q;
    if (lut_we) begin
      lut_d[lut_waddr] = lut_wdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    wrap_err_d = wrap_err_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_RUN;
          pc_d       = '0;
          cnt_d      = '0;
          wrap_err_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (halt) begin
          state_d = ST_DONE;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (abs_jump) begin
          pc_d = target;
        end else if (branch_en && jump_flag) begin
          // Table entry is a two's-complement offset; the add wraps silently.
          pc_d = pc_q + target;
        end else begin
          pc_d = pc_q + PC_W'(1);
          if (pc_q == '1) begin
            wrap_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      wrap_err_q <= 1'b0;
      cnt_q      <= '0;
      for (int i = 0; i < LUT_N; i++) begin
        lut_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      wrap_err_q <= wrap_err_d;
      cnt_q      <= cnt_d;
      lut_q      <= lut_d;
    end
  end

  assign pc          = pc_q;
  assign running     = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign pc_wrap_err = wrap_err_q;
  assign cycle_cnt   = cnt_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: directed scenarios plus random traffic against a behavioural model;
// a second instance with a 4-bit counter exercises saturation.
module tb_pc_ctrl;

  localparam int PC_W   = 10;
  localparam int LUT_AW = 4;
  localparam int CNT_W  = 16;
  localparam int CNT_W2 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, start, stall, halt, branch_en, abs_jump, jump_flag, lut_we;
  logic [LUT_AW-1:0] lut_idx, lut_waddr;
  logic [PC_W-1:0]   lut_wdata;

  logic [PC_W-1:0]   pc0, pc1;
  logic              running0, running1, done0, done1, err0, err1;
  logic [CNT_W-1:0]  cnt0;
  logic [CNT_W2-1:0] cnt1;

  pc_ctrl #(.PC_W(PC_W), .LUT_AW(LUT_AW), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
    .branch_en(branch_en), .abs_jump(abs_jump), .jump_flag(jump_flag),
    .lut_idx(lut_idx), .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .pc(pc0), .running(running0), .done(done0), .pc_wrap_err(err0), .cycle_cnt(cnt0)
  );

  pc_ctrl #(.PC_W(PC_W), .LUT_AW(LUT_AW), .CNT_W(CNT_W2)) u_dut_sat (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
    .branch_en(branch_en), .abs_jump(abs_jump), .jump_flag(jump_flag),
    .lut_idx(lut_idx), .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .pc(pc1), .running(running1), .done(done1), .pc_wrap_err(err1), .cycle_cnt(cnt1)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: mode 0=idle, 1=run, 2=done; run length kept unbounded.
  int m_mode = 0;
  int m_pc   = 0;
  int m_runs = 0;
  bit m_err  = 1'b0;
  int m_lut [16];
  bit chk_en = 1'b0;

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  always @(posedge clk) begin : model
    int t, off;
    if (reset) begin
      m_mode = 0; m_pc = 0; m_runs = 0; m_err = 1'b0;
      for (int i = 0; i < 16; i++) m_lut[i] = 0;
      chk_en = 1'b1;
    end else begin
      t = m_lut[lut_idx];
      if (m_mode == 1) begin
        m_runs = m_runs + 1;
        if (halt) m_mode = 2;
        else if (stall) m_pc = m_pc;
        else if (abs_jump) m_pc = t;
        else if (branch_en && jump_flag) begin
          off  = (t >= 512) ? t - 1024 : t;
          m_pc = (m_pc + off + 1024) % 1024;
        end else begin
          if (m_pc == 1023) m_err = 1'b1;
          m_pc = (m_pc + 1) % 1024;
        end
      end else if (start) begin
        m_mode = 1; m_pc = 0; m_runs = 0; m_err = 1'b0;
      end
      if (lut_we) m_lut[lut_waddr] = int'(lut_wdata);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("pc",        32'(pc0),      32'(m_pc));
      cmp("running",   32'(running0), 32'(m_mode == 1));
      cmp("done",      32'(done0),    32'(m_mode == 2));
      cmp("wrap_err",  32'(err0),     32'(m_err));
      cmp("cycle_cnt", 32'(cnt0),     32'(sat(m_runs, 65535)));
      cmp("pc_sat",    32'(pc1),      32'(m_pc));
      cmp("cnt_sat",   32'(cnt1),     32'(sat(m_runs, 15)));
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    reset = 0; start = 0; stall = 0; halt = 0; branch_en = 0; abs_jump = 0;
    jump_flag = 0; lut_we = 0; lut_idx = '0; lut_waddr = '0; lut_wdata = '0;
  endtask

  task automatic wr(input int a, input int d);
    stall = 1; lut_we = 1; lut_waddr = LUT_AW'(a); lut_wdata = PC_W'(d);
    step();
  endtask

  initial begin
    reset = 1; start = 0; stall = 0; halt = 0; branch_en = 0; abs_jump = 0;
    jump_flag = 0; lut_we = 0; lut_idx = '0; lut_waddr = '0; lut_wdata = '0;
    step(); reset = 1; step();
    cmp("rst_pc", 32'(pc0), 32'h0);
    cmp("rst_running", 32'(running0), 32'h0);
    cmp("rst_done", 32'(done0), 32'h0);
    cmp("rst_err", 32'(err0), 32'h0);
    cmp("rst_cnt", 32'(cnt0), 32'h0);

    start = 1; step();
    cmp("start_pc", 32'(pc0), 32'h0);
    repeat (5) step();
    cmp("seq_pc", 32'(pc0), 32'h5);
    cmp("seq_cnt", 32'(cnt0), 32'h5);
    cmp("seq_running", 32'(running0), 32'h1);
    cmp("seq_done", 32'(done0), 32'h0);

    repeat (3) step();
    wr(3, 10'h3FE);
    cmp("pc_before_br", 32'(pc0), 32'h8);
    branch_en = 1; jump_flag = 1; lut_idx = 3; step();
    cmp("br_taken", 32'(pc0), 32'h6);
    step(); step();
    branch_en = 1; jump_flag = 0; lut_idx = 3; step();
    cmp("br_not_taken", 32'(pc0), 32'h9);

    wr(1, 10'h100);
    stall = 1; abs_jump = 1; lut_idx = 1; step();
    cmp("stall_over_jump", 32'(pc0), 32'h9);
    abs_jump = 1; lut_idx = 1; step();
    cmp("abs_jump", 32'(pc0), 32'h100);
    halt = 1; abs_jump = 1; lut_idx = 1; step();
    cmp("halt_done", 32'(done0), 32'h1);
    cmp("halt_pc", 32'(pc0), 32'h100);

    lut_we = 1; lut_waddr = 4; lut_wdata = 10'h3FF; step();
    start = 1; step();
    abs_jump = 1; lut_idx = 4; step();
    cmp("jump_top", 32'(pc0), 32'h3FF);
    step();
    cmp("wrap_pc", 32'(pc0), 32'h0);
    cmp("wrap_err", 32'(err0), 32'h1);
    halt = 1; step();
    cmp("done_err_hold", 32'(err0), 32'h1);
    start = 1; step();
    cmp("restart_err", 32'(err0), 32'h0);
    cmp("restart_pc", 32'(pc0), 32'h0);

    wr(2, 10'h010);
    lut_we = 1; lut_waddr = 2; lut_wdata = 10'h050; abs_jump = 1; lut_idx = 2; step();
    cmp("rd_old", 32'(pc0), 32'h010);
    abs_jump = 1; lut_idx = 2; step();
    cmp("rd_new", 32'(pc0), 32'h050);

    wr(5, 10'h123);
    wr(6, 10'h037);
    abs_jump = 1; lut_idx = 6; step();
    cmp("pc_37", 32'(pc0), 32'h37);
    reset = 1; step();
    cmp("midrun_rst_pc", 32'(pc0), 32'h0);
    cmp("midrun_rst_cnt", 32'(cnt0), 32'h0);
    cmp("midrun_rst_running", 32'(running0), 32'h0);
    start = 1; step();
    abs_jump = 1; lut_idx = 5; step();
    cmp("lut_cleared", 32'(pc0), 32'h0);

    reset = 1; step();
    start = 1; step();
    repeat (20) step();
    cmp("sat_cnt4", 32'(cnt1), 32'hF);
    cmp("cnt16_20", 32'(cnt0), 32'd20);
    cmp("pc_20", 32'(pc0), 32'd20);

    repeat (3000) begin
      reset     = ($urandom % 300) == 0;
      start     = ($urandom % 8) == 0;
      stall     = ($urandom % 6) == 0;
      halt      = ($urandom % 30) == 0;
      branch_en = ($urandom % 4) == 0;
      abs_jump  = ($urandom % 8) == 0;
      jump_flag = 1'($urandom);
      lut_idx   = LUT_AW'($urandom);
      lut_we    = ($urandom % 5) == 0;
      lut_waddr = LUT_AW'($urandom);
      lut_wdata = PC_W'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
